// File: rtl/contador_pkg.sv
// Shared types for the down counter.
// State encoding and default counter width.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cnt_state_t;

  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/decrementador_borrow.sv
// Combinational WIDTH-bit decrement (a - 1) built as a borrow chain.
// Ports: a (operand), diff (a - 1), borrow_out (set only when a == 0).
module decrementador_borrow #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0] b;

  always_comb begin
    b[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i]  = a[i] ^ b[i];
      b[i+1]   = ~a[i] & b[i];
    end
    borrow_out = b[WIDTH];
  end

endmodule

// File: rtl/contador_regresivo.sv
// Loadable down counter with a one-cycle terminal-count pulse.
// Ports: clk, rst (sync, active-high), load, D, en -> Q, busy, zero, done.
// Build option CONTADOR_AUTORELOAD_EN: terminal step reloads and keeps running.
module contador_regresivo
  import contador_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  cnt_state_t       state_q;
  cnt_state_t       state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             done_q;
  logic             done_d;

  logic [WIDTH-1:0] dec_diff;
  logic             dec_borrow;
  logic             term;
  logic             run_step;
  logic             in_done;
  logic [WIDTH-1:0] term_value;
  cnt_state_t       term_state;

  decrementador_borrow #(
    .WIDTH(WIDTH)
  ) u_dec (
    .a         (q_q),
    .diff      (dec_diff),
    .borrow_out(dec_borrow)
  );

  // Count of 1 is the only operand whose decrement is zero
  // without a borrow; a count of 0 borrows and must never wrap.
  assign term = ~dec_borrow & (dec_diff == '0);

  assign run_step = ~load & (state_q == RUN) & en;
  assign in_done  = ~load & (state_q == DONE);

`ifdef CONTADOR_AUTORELOAD_EN
  assign term_value = reload_q;
  assign term_state = RUN;
`else
  assign term_value = '0;
  assign term_state = DONE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      load: begin
        state_d = (D != '0) ? RUN : IDLE;
      end
      run_step && term: begin
        state_d = term_state;
      end
      in_done: begin
        state_d = IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (1'b1)
      load: begin
        q_d      = D;
        reload_d = D;
      end
      run_step && term: begin
        q_d    = term_value;
        done_d = 1'b1;
      end
      run_step && !term: begin
        q_d = dec_diff;
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign Q    = q_q;
  assign zero = (q_q == '0);
  assign done = done_q;

endmodule

// File: tb/tb_contador_regresivo.sv
// Self-checking bench for contador_regresivo.
// Behavioural model plus hand-computed directed checks.
module tb_contador_regresivo;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] D;
  logic       en;
  logic [3:0] Q;
  logic       busy;
  logic       zero;
  logic       done;

  int n_cmp;
  int n_bad;
  bit chk_on;

  // model: remaining count, preset, mode (0 idle,1 counting,2 finished)
  int m_cnt;
  int m_pre;
  int m_mode;
  bit m_done;

  contador_regresivo #(
    .WIDTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .load(load),
    .D   (D),
    .en  (en),
    .Q   (Q),
    .busy(busy),
    .zero(zero),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit l, input int d,
                              input bit e);
    if (r) begin
      m_cnt = 0; m_pre = 0; m_mode = 0; m_done = 0;
    end else if (l) begin
      m_cnt  = d;
      m_pre  = d;
      m_mode = (d != 0) ? 1 : 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode == 2) begin
        m_mode = 0;
      end else if (m_mode == 1 && e) begin
        if (m_cnt == 1) begin
          m_done = 1;
`ifdef CONTADOR_AUTORELOAD_EN
          m_cnt = m_pre;
`else
          m_cnt  = 0;
          m_mode = 2;
`endif
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input int d, input bit e);
    @(negedge clk);
    rst  = r;
    load = l;
    D    = 4'(d);
    en   = e;
    @(posedge clk);
    model_update(r, l, d, e);
    chk_on = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_q", int'(Q), m_cnt);
      chk("model_busy", int'(busy), (m_mode == 1) ? 1 : 0);
      chk("model_zero", int'(zero), (m_cnt == 0) ? 1 : 0);
      chk("model_done", int'(done), int'(m_done));
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; chk_on = 1'b0;
    rst = 1'b1; load = 1'b0; D = 4'd0; en = 1'b0;

    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rst_q", int'(Q), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_busy", int'(busy), 0);
    step(0, 0, 0, 1);
    chk("idle_q", int'(Q), 0);
    chk("idle_done", int'(done), 0);

`ifndef CONTADOR_AUTORELOAD_EN
    // one-shot D=3
    step(0, 1, 3, 1);
    chk("os_load_q", int'(Q), 3);
    chk("os_load_busy", int'(busy), 1);
    step(0, 0, 0, 1); chk("os_q2", int'(Q), 2);
    step(0, 0, 0, 1); chk("os_q1", int'(Q), 1);
    chk("os_nodone", int'(done), 0);
    step(0, 0, 0, 1);
    chk("os_q0", int'(Q), 0);
    chk("os_done", int'(done), 1);
    chk("os_busy0", int'(busy), 0);
    step(0, 0, 0, 1);
    chk("os_done_clr", int'(done), 0);

    // enable gaps
    step(0, 1, 2, 0); chk("gap_load", int'(Q), 2);
    step(0, 0, 0, 1); chk("gap_q1", int'(Q), 1);
    step(0, 0, 0, 0); chk("gap_hold1", int'(Q), 1);
    step(0, 0, 0, 0); chk("gap_hold2", int'(busy), 1);
    step(0, 0, 0, 1);
    chk("gap_q0", int'(Q), 0);
    chk("gap_done", int'(done), 1);
    step(0, 0, 0, 0);

    // reload mid-count, load wins over en
    step(0, 1, 9, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); chk("rl_q7", int'(Q), 7);
    step(0, 1, 4, 1); chk("rl_q4", int'(Q), 4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); chk("rl_q1", int'(Q), 1);
    step(0, 0, 0, 1); chk("rl_done", int'(done), 1);
    // load honored in the DONE cycle
    step(0, 1, 2, 1);
    chk("dn_load_q", int'(Q), 2);
    chk("dn_load_busy", int'(busy), 1);
    chk("dn_load_done", int'(done), 0);

    // load zero
    step(0, 1, 0, 1);
    chk("z_q", int'(Q), 0);
    chk("z_busy", int'(busy), 0);
    step(0, 0, 0, 1);
    chk("z_nodone", int'(done), 0);

    // full range
    step(0, 1, 15, 1);
    for (int i = 1; i <= 14; i++) step(0, 0, 0, 1);
    chk("f_q1", int'(Q), 1);
    step(0, 0, 0, 1);
    chk("f_done", int'(done), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("f_nowrap", int'(Q), 0);

    // reset mid-count
    step(0, 1, 5, 0);
    step(1, 0, 0, 1);
    chk("rm_q", int'(Q), 0);
    chk("rm_done", int'(done), 0);
    chk("rm_busy", int'(busy), 0);
    step(0, 0, 0, 1);
`else
    step(0, 1, 2, 1); chk("ar_q0", int'(Q), 2);
    step(0, 0, 0, 1); chk("ar_q1", int'(Q), 1);
    step(0, 0, 0, 1); chk("ar_q2", int'(Q), 2);
    chk("ar_d2", int'(done), 1);
    step(0, 0, 0, 1); chk("ar_d3", int'(done), 0);
    step(0, 0, 0, 1); chk("ar_d4", int'(done), 1);
    step(0, 0, 0, 1); chk("ar_q5", int'(Q), 1);
    step(0, 0, 0, 1); chk("ar_d6", int'(done), 1);
    chk("ar_busy", int'(busy), 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 1); chk("ar1_done", int'(done), 1);
    step(0, 0, 0, 1); chk("ar1_done2", int'(done), 1);
    step(0, 1, 0, 1); chk("ar_stop", int'(busy), 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
`endif

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
